// File: rtl/icache_assoc_param.sv
// N-way set-associative instruction cache: combinational lookup, single-line refill
// with per-set round-robin replacement, walked whole-cache flush and saturating counters.
module icache_assoc_param #(
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 32,
  parameter int WAYS           = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 pc_i,
  input  logic                        fetch_valid_i,
  input  logic                        flush_i,
  output logic                        mem_req_o,
  output logic [31:0]                 mem_addr_o,
  input  logic                        mem_ready_i,
  input  logic [32*WORDS_PER_LINE-1:0] mem_data_i,
  output logic                        stall_o,
  output logic [31:0]                 instr_o,
  output logic                        instr_valid_o,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o,
  output logic [1:0]                  state_o
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int LA_W   = 32 - OFF_W;

  // Handshake: mem_req_o rises on the miss edge and stays high until the first
  // edge where mem_ready_i is sampled high; mem_data_i is taken on that edge.
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH_MEM, ST_REFILL, ST_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [LA_W-1:0]    miss_line_q, miss_line_d;
  logic               mem_req_q, mem_req_d;
  logic [LINE_W-1:0]  line_buf_q, line_buf_d;
  logic               flush_pending_q, flush_pending_d;
  logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [RR_W-1:0]    rr_q    [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]  data_q  [SETS][WAYS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  wsel;
  logic               hit;
  logic [RR_W-1:0]    hit_way;
  logic [LINE_W-1:0]  hit_line;
  logic [31:0]        hit_word;
  logic [IDX_W-1:0]   miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic [RR_W-1:0]    victim;
  logic               victim_free;
  logic               unused_pc;

  assign idx       = pc_i[OFF_W+IDX_W-1:OFF_W];
  assign tag       = pc_i[31:OFF_W+IDX_W];
  assign wsel      = pc_i[OFF_W-1:2];
  assign unused_pc = ^pc_i[1:0];
  assign miss_idx  = miss_line_q[IDX_W-1:0];
  assign miss_tag  = miss_line_q[LA_W-1:IDX_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = RR_W'(w);
      end
    end
  end

  assign hit_line = data_q[idx][hit_way];

  always_comb begin
    hit_word = '0;
    for (int wd = 0; wd < WORDS_PER_LINE; wd++) begin
      if (wsel == WSEL_W'(wd)) hit_word = hit_line[wd*32 +: 32];
    end
  end

  // Prefer the lowest-numbered invalid way; only a full set consults rr.
  always_comb begin
    victim      = rr_q[miss_idx];
    victim_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[miss_idx][w]) begin
        victim      = RR_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  assign instr_valid_o = (state_q == ST_IDLE) && fetch_valid_i && hit && !flush_i;
  assign instr_o       = instr_valid_o ? hit_word : 32'h0000_0013;
  assign stall_o       = (state_q != ST_IDLE) || flush_i || (fetch_valid_i && !hit);
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = {miss_line_q, {OFF_W{1'b0}}};
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;
  assign state_o       = state_q;

  always_comb begin
    state_d         = state_q;
    miss_line_d     = miss_line_q;
    mem_req_d       = mem_req_q;
    line_buf_d      = line_buf_q;
    flush_pending_d = flush_pending_q;
    flush_idx_d     = flush_idx_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    if (instr_valid_o && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end else if (fetch_valid_i && !hit) begin
          state_d     = ST_FETCH_MEM;
          miss_line_d = pc_i[31:OFF_W];
          mem_req_d   = 1'b1;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      ST_FETCH_MEM: begin
        if (flush_i) flush_pending_d = 1'b1;
        if (mem_ready_i) begin
          line_buf_d = mem_data_i;
          mem_req_d  = 1'b0;
          state_d    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        flush_pending_d = 1'b0;
        flush_idx_d     = '0;
        state_d         = (flush_pending_q || flush_i) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_idx_q == IDX_W'(SETS - 1)) begin
          flush_idx_d = '0;
          state_d     = ST_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      miss_line_q     <= '0;
      mem_req_q       <= 1'b0;
      line_buf_q      <= '0;
      flush_pending_q <= 1'b0;
      flush_idx_q     <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      miss_line_q     <= miss_line_d;
      mem_req_q       <= mem_req_d;
      line_buf_q      <= line_buf_d;
      flush_pending_q <= flush_pending_d;
      flush_idx_q     <= flush_idx_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == ST_REFILL) begin
      valid_q[miss_idx][victim] <= 1'b1;
      if (!victim_free) rr_q[miss_idx] <= (WAYS > 1) ? rr_q[miss_idx] + RR_W'(1) : '0;
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      rr_q[flush_idx_q]    <= '0;
    end
  end

  // Tag and data storage carry no reset; valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (state_q == ST_REFILL) begin
      tag_q[miss_idx][victim]  <= miss_tag;
      data_q[miss_idx][victim] <= line_buf_q;
    end
  end

endmodule

// File: tb/tb_icache_assoc_param.sv
// Bench for icache_assoc_param: a 2-way and a 4-way instance, exercised one at a time
// with directed and random fetches against a per-set line-list reference model.
module tb_icache_assoc_param;
  localparam int SETS = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         sel;
  logic [31:0]  pc;
  logic         fv, fl, mr;
  logic [127:0] md;

  logic         mem_req2, mem_req4, stall2, stall4, iv2, iv4;
  logic [31:0]  mem_addr2, mem_addr4, instr2, instr4, hc2, hc4, mc2, mc4;
  logic [1:0]   dbg_state_unused2, dbg_state_unused4;

  logic         mem_req, stall, iv;
  logic [31:0]  mem_addr, instr, hc, mc;

  int           n_checks, n_errors;
  int           ways;
  logic         m_valid [SETS][4];
  logic [27:0]  m_line  [SETS][4];
  int           m_rr    [SETS];
  int           m_hits, m_misses;

  always #5 clock = ~clock;

  icache_assoc_param #(.WORDS_PER_LINE(4), .SETS(SETS), .WAYS(2)) dut2 (
    .clock(clock), .reset(reset), .pc_i(pc), .fetch_valid_i(fv & ~sel),
    .flush_i(fl & ~sel), .mem_req_o(mem_req2), .mem_addr_o(mem_addr2),
    .mem_ready_i(mr & ~sel), .mem_data_i(md), .stall_o(stall2), .instr_o(instr2),
    .instr_valid_o(iv2), .hit_cnt_o(hc2), .miss_cnt_o(mc2), .state_o(dbg_state_unused2)
  );

  icache_assoc_param #(.WORDS_PER_LINE(4), .SETS(SETS), .WAYS(4)) dut4 (
    .clock(clock), .reset(reset), .pc_i(pc), .fetch_valid_i(fv & sel),
    .flush_i(fl & sel), .mem_req_o(mem_req4), .mem_addr_o(mem_addr4),
    .mem_ready_i(mr & sel), .mem_data_i(md), .stall_o(stall4), .instr_o(instr4),
    .instr_valid_o(iv4), .hit_cnt_o(hc4), .miss_cnt_o(mc4), .state_o(dbg_state_unused4)
  );

  assign mem_req  = sel ? mem_req4  : mem_req2;
  assign mem_addr = sel ? mem_addr4 : mem_addr2;
  assign stall    = sel ? stall4    : stall2;
  assign iv       = sel ? iv4       : iv2;
  assign instr    = sel ? instr4    : instr2;
  assign hc       = sel ? hc4       : hc2;
  assign mc       = sel ? mc4       : mc2;

  // Backing memory: the line at 0x100 holds 0x11,0x22,0x33,0x44; elsewhere a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wd;
    wd = {30'b0, a[3:2]};
    if (a[31:4] == 28'h10) return 32'h11 * (wd + 32'd1);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [127:0] l;
    for (int wd = 0; wd < 4; wd++) l[wd*32 +: 32] = mem_word({a[31:4], 4'b0} + 32'(wd * 4));
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic model_lookup(input logic [31:0] a, output bit h);
    int s;
    s = int'(a[8:4]);
    h = 1'b0;
    for (int w = 0; w < ways; w++) if (m_valid[s][w] && m_line[s][w] == a[31:4]) h = 1'b1;
  endtask

  task automatic model_fill(input logic [31:0] a);
    int s, v;
    s = int'(a[8:4]);
    v = -1;
    for (int w = 0; w < ways; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % ways;
    end
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = a[31:4];
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fv = 1'b0; fl = 1'b0; mr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic idle(input int n);
    fv = 1'b0; fl = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_instr", instr, 32'h13);
      tick();
    end
  endtask

  // One fetch; on a miss serve the line after k request cycles, optionally with
  // a flush pulse and/or a wandering pc while the request is outstanding.
  task automatic fetch(input logic [31:0] a, input int k, input bit mid_flush,
                       input bit wander, output bit missed);
    bit h;
    pc = a; fv = 1'b1; fl = 1'b0; mr = 1'b0;
    model_lookup(a, h);
    #1;
    missed = stall;
    check("lookup_stall", 32'(stall), 32'(!h));
    if (h) begin
      check("hit_valid", 32'(iv), 32'd1);
      check("hit_instr", instr, mem_word(a));
      m_hits++;
      tick();
      return;
    end
    check("miss_valid", 32'(iv), 32'd0);
    check("miss_instr", instr, 32'h13);
    m_misses++;
    tick();
    for (int i = 1; i <= k; i++) begin
      check("req_high", 32'(mem_req), 32'd1);
      check("req_addr", mem_addr, {a[31:4], 4'b0});
      check("req_stall", 32'(stall), 32'd1);
      if (wander) pc = $urandom & 32'hFFFF_FFFC;
      fl = (mid_flush && i == 1);
      if (i == k) begin
        mr = 1'b1;
        md = line_data(a);
      end
      tick();
    end
    mr = 1'b0; fl = 1'b0; md = {4{$urandom}}; pc = a;
    #1;
    check("refill_stall", 32'(stall), 32'd1);
    check("refill_req", 32'(mem_req), 32'd0);
    check("refill_valid", 32'(iv), 32'd0);
    model_fill(a);
    tick();
    if (mid_flush) begin
      fv = 1'b0;
      for (int i = 0; i < SETS; i++) begin
        #1;
        check("midflush_stall", 32'(stall), 32'd1);
        tick();
      end
      #1;
      check("midflush_done", 32'(stall), 32'd0);
      model_flush();
      return;
    end
    #1;
    check("miss_then_hit", 32'(iv), 32'd1);
    check("miss_then_instr", instr, mem_word(a));
    m_hits++;
    tick();
  endtask

  task automatic flush_idle(input logic [31:0] a);
    int cnt;
    pc = a; fv = 1'b1; fl = 1'b1;
    #1;
    check("flush_cycle_stall", 32'(stall), 32'd1);
    check("flush_cycle_valid", 32'(iv), 32'd0);
    tick();
    fl = 1'b0; fv = 1'b0;
    cnt = 0;
    while (cnt < 200) begin
      #1;
      if (!stall) break;
      cnt++;
      tick();
    end
    check("flush_walk_cycles", 32'(cnt), 32'(SETS));
    model_flush();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hits"}, hc, 32'(m_hits));
    check({tag, "_misses"}, mc, 32'(m_misses));
  endtask

  task automatic run_table(input string tag, input logic [31:0] addrs[$], input bit exp_miss[$]);
    bit m;
    for (int i = 0; i < addrs.size(); i++) begin
      fetch(addrs[i], 1 + (i % 3), 1'b0, 1'b0, m);
      check(tag, 32'(m), 32'(exp_miss[i]));
    end
  endtask

  task automatic random_phase(input int n);
    bit m;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      idle($urandom_range(1, 3));
      else if (r == 1) flush_idle(rand_addr());
      else             fetch(rand_addr(), $urandom_range(1, 4), r == 2, 1'b1, m);
    end
  endtask

  initial begin
    bit m;
    n_checks = 0; n_errors = 0;
    sel = 1'b0; ways = 2;
    reset = 1'b1; pc = '0; fv = 1'b0; fl = 1'b0; mr = 1'b0; md = '0;
    model_reset();
    tick();
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_instr", instr, 32'h13);
    check("reset_hits", hc, 32'd0);
    check("reset_misses", mc, 32'd0);
    reset = 1'b0;
    tick();

    fetch(32'h100, 3, 1'b0, 1'b0, m);
    check("cold_miss", 32'(m), 32'd1);
    run_table("cold_line_hit", '{32'h104, 32'h108, 32'h10C}, '{1'b0, 1'b0, 1'b0});
    check("cold_hits", hc, 32'd4);
    check("cold_misses", mc, 32'd1);

    run_table("assoc2", '{32'h000, 32'h200, 32'h000, 32'h200, 32'h400, 32'h200, 32'h000},
              '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    fetch(32'h100, 1, 1'b0, 1'b0, m);
    check("warm_before_flush", 32'(m), 32'd0);
    flush_idle(32'h100);
    fetch(32'h100, 2, 1'b0, 1'b0, m);
    check("miss_after_flush", 32'(m), 32'd1);
    check_counters("after_flush");

    fetch(32'h300, 3, 1'b1, 1'b0, m);
    fetch(32'h300, 1, 1'b0, 1'b0, m);
    check("midflush_line_gone", 32'(m), 32'd1);

    pc = 32'h500; fv = 1'b1;
    tick();
    check("pre_reset_req", 32'(mem_req), 32'd1);
    reset = 1'b1; fv = 1'b0;
    #1;
    check("async_reset_req", 32'(mem_req), 32'd0);
    check("async_reset_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    mr = 1'b1; md = line_data(32'h500);
    tick();
    mr = 1'b0;
    check("stale_ready_req", 32'(mem_req), 32'd0);
    check("stale_ready_misses", mc, 32'd0);
    fetch(32'h500, 2, 1'b0, 1'b0, m);
    check("stale_ready_no_alloc", 32'(m), 32'd1);

    random_phase(150);
    check_counters("random_w2");

    sel = 1'b1; ways = 4;
    do_reset();
    run_table("rr4",
      '{32'h000, 32'h200, 32'h400, 32'h600, 32'h000, 32'h800, 32'h200, 32'h400,
        32'h600, 32'h800, 32'hA00, 32'h400, 32'h600, 32'h800, 32'h000, 32'h200,
        32'h400, 32'hA00, 32'h000, 32'h200, 32'h800},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
        1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    check_counters("rr4");

    random_phase(120);
    check_counters("random_w4");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
